registered_adder_tree_pipe: RTL and testbench
=============================================

Name: registered_adder_tree_pipe

Overview:
- Parametrised, fully pipelined signed adder tree. Sums NUM_INPUTS operands of IN_WIDTH bits through a registered binary tree.
- Generalises the fixed 3-input single-stage registered adder: arbitrary operand count, one register level per tree level, valid pipeline with enable stall, and an early-ready lookahead.
- Sits between linear-algebra datapath stages (dot-product and matrix-vector reduction) and downstream accumulators.

Parameters:
- IN_WIDTH, 10, signed width of each operand.
- NUM_INPUTS, 5, operand count; legal range 2..64.
- SAT_WIDTH, 12, saturation width in bits; used only when the optional feature is compiled in; must satisfy 2 <= SAT_WIDTH <= OUT_W.
- Derived (localparam): LEVELS = clog2(NUM_INPUTS); OUT_W = IN_WIDTH + LEVELS.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  reset, synchronous, active-high.
- enable  input  1  global pipeline advance; low freezes every register.
- inReady  input  1  operand bus valid this cycle.
- I  input  NUM_INPUTS*IN_WIDTH  packed signed operands; operand k occupies bits [k*IN_WIDTH +: IN_WIDTH].
- outReady  output  1  registered; out holds a new valid sum.
- out  output  OUT_W  registered signed sum.
- earlyOutReady  output  1  combinational; equals the value outReady takes at the next enabled edge.

Behaviour:
- Tree structure:
  - Level 0 = input operands.
  - Level L+1 pairs adjacent level-L terms (2j, 2j+1) and adds them, widening by one bit with sign extension.
  - An odd leftover term passes through sign-extended and registered, so every path has identical latency.
- Each level has a data register bank and one valid bit v[L], L = 1..LEVELS; out/outReady are level LEVELS.
- Latency: exactly LEVELS enabled clock edges from inReady sampled high to outReady high. Throughput is one sum per enabled cycle.
- On an enabled edge:
  - v[1] <= inReady; v[L+1] <= v[L].
  - Level data registers load only when their incoming valid is 1; on a bubble they hold their previous value.
- enable=0: all valid bits and data registers hold, including outReady and out. inReady is ignored on that edge, so an operand presented while enable=0 is lost.
- reset=1 (priority over enable): all v[L] <= 0, outReady <= 0, out <= 0. Internal data registers are not cleared. Reset mid-flight discards every in-flight sum; no stale outReady follows reset deassertion.
- earlyOutReady = v[LEVELS-1], or inReady when LEVELS=1. It is forced to 0 while reset=1.
- Arithmetic is two's complement. Full growth is carried, so no overflow is possible without the optional feature.
- Back-to-back and bubble patterns are preserved exactly: an outReady pattern equals the inReady pattern delayed by LEVELS enabled edges.

Optional Feature:
- Macro: ADDER_TREE_SAT_EN.
- Defined: the final-level sum is clamped to the signed SAT_WIDTH range [-2^(SAT_WIDTH-1), 2^(SAT_WIDTH-1)-1], then sign-extended to OUT_W. This adds one extra output register stage: latency becomes LEVELS+1, and earlyOutReady tracks v[LEVELS].
- Undefined: no clamping; latency is LEVELS; SAT_WIDTH is unused.

Test Plan:
1. Defaults (N=5, W=10, LEVELS=3): inReady one cycle with operands 1,2,3,4,5 -> outReady high exactly 3 edges later for 1 cycle, out=15; earlyOutReady high the cycle before.
2. All operands 511, then all -512, back-to-back -> out=2555 then -2560 on consecutive cycles, outReady high 2 cycles.
3. Stream 4 valid vectors with enable low for 2 cycles mid-stream -> all outputs frozen during the stall; 4 correct sums emerge in order, latency extended by exactly 2.
4. Assert reset for 1 cycle while 2 sums are in flight -> outReady=0 and out=0 next cycle; no outReady pulse for the discarded sums; the next vector sums correctly.
5. Bubble pattern inReady=1,0,1,1,0 -> outReady=1,0,1,1,0 after 3 edges; out holds its last value through bubbles.
6. With ADDER_TREE_SAT_EN and SAT_WIDTH=12: all operands 511 -> out=2047; all -512 -> out=-2048; operands 1..5 -> 15; latency 4.

Source files
------------

// File: rtl/registered_adder_tree_pipe.sv
// Fully pipelined signed adder tree: one register level per binary-tree level, with a valid chain.
// Define ADDER_TREE_SAT_EN to clamp the sum to SAT_WIDTH bits through one extra output stage.
module registered_adder_tree_pipe #(
   parameter int unsigned IN_WIDTH   = 10,
   parameter int unsigned NUM_INPUTS = 5,
   parameter int unsigned SAT_WIDTH  = 12,
   localparam int unsigned LEVELS    = $clog2(NUM_INPUTS),
   localparam int unsigned OUT_W     = IN_WIDTH + LEVELS
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           enable,
   input  logic                           inReady,
   input  logic [NUM_INPUTS*IN_WIDTH-1:0] I,
   output logic                           outReady,
   output logic signed [OUT_W-1:0]        out,
   output logic                           earlyOutReady
);

   function automatic int unsigned level_cnt(int unsigned lv);
      return (NUM_INPUTS + (32'd1 << lv) - 32'd1) >> lv;
   endfunction

   function automatic int unsigned level_base(int unsigned lv);
      int unsigned b;
      b = 0;
      for (int unsigned l = 0; l < lv; l++) b += level_cnt(l);
      return b;
   endfunction

`ifdef ADDER_TREE_SAT_EN
   localparam bit SatEn = 1'b1;
`else
   localparam bit SatEn = 1'b0;
`endif

   localparam int unsigned NumNodes = level_base(LEVELS + 1);
   localparam int unsigned RootIdx  = level_base(LEVELS);

   if (NUM_INPUTS < 2 || NUM_INPUTS > 64) begin : gen_bad_num
      $error("NUM_INPUTS must be within 2..64");
   end
   if (SatEn && (SAT_WIDTH < 2 || SAT_WIDTH > OUT_W)) begin : gen_bad_sat
      $error("SAT_WIDTH must be within 2..OUT_W");
   end

   // Every tree node, level by level, each OUT_W wide and sign-extended.
   logic [NumNodes*OUT_W-1:0] tree;
   logic [LEVELS:1]           v_q, v_d;
   logic [LEVELS:0]           vld;
   logic signed [OUT_W-1:0]   root;

   assign vld  = {v_q, inReady};
   assign root = tree[RootIdx*OUT_W +: OUT_W];

   always_comb begin
      v_d = v_q;
      if (enable) v_d = vld[LEVELS-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) v_q <= '0;
      else       v_q <= v_d;
   end

   for (genvar k = 0; k < NUM_INPUTS; k++) begin : gen_in
      assign tree[k*OUT_W +: OUT_W] =
         {{LEVELS{I[k*IN_WIDTH+IN_WIDTH-1]}}, I[k*IN_WIDTH +: IN_WIDTH]};
   end

   for (genvar lv = 1; lv <= LEVELS; lv++) begin : gen_lvl
      localparam int unsigned Cnt  = level_cnt(lv);
      localparam int unsigned PCnt = level_cnt(lv - 1);
      localparam int unsigned Src  = level_base(lv - 1);
      localparam int unsigned Dst  = level_base(lv);
      // Only the visible output register is cleared; internal data just goes stale.
      localparam bit ClrOnRst = (lv == LEVELS) && !SatEn;

      for (genvar j = 0; j < Cnt; j++) begin : gen_node
         logic signed [OUT_W-1:0] node_sum;
         logic signed [OUT_W-1:0] sum_d, sum_q;

         if (2*j + 1 < PCnt) begin : gen_pair
            always_comb begin
               node_sum = signed'(tree[(Src+2*j)*OUT_W +: OUT_W])
                        + signed'(tree[(Src+2*j+1)*OUT_W +: OUT_W]);
            end
         end else begin : gen_pass
            always_comb begin
               node_sum = signed'(tree[(Src+2*j)*OUT_W +: OUT_W]);
            end
         end

         always_comb begin
            sum_d = sum_q;
            if (enable && vld[lv-1]) sum_d = node_sum;
         end

         always_ff @(posedge clk) begin
            if (reset && ClrOnRst) sum_q <= '0;
            else                   sum_q <= sum_d;
         end

         assign tree[(Dst+j)*OUT_W +: OUT_W] = sum_q;
      end
   end

`ifdef ADDER_TREE_SAT_EN
   localparam longint SatMaxL = (longint'(1) <<< (SAT_WIDTH - 1)) - 1;
   localparam logic signed [OUT_W-1:0] SatMax = OUT_W'(SatMaxL);
   localparam logic signed [OUT_W-1:0] SatMin = OUT_W'(-SatMaxL - 1);

   logic                    sat_v_d, sat_v_q;
   logic signed [OUT_W-1:0] sat_d, sat_q;

   always_comb begin
      sat_v_d = sat_v_q;
      sat_d   = sat_q;
      if (enable) begin
         sat_v_d = v_q[LEVELS];
         if (v_q[LEVELS]) begin
            if (root > SatMax)      sat_d = SatMax;
            else if (root < SatMin) sat_d = SatMin;
            else                    sat_d = root;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sat_v_q <= 1'b0;
         sat_q   <= '0;
      end else begin
         sat_v_q <= sat_v_d;
         sat_q   <= sat_d;
      end
   end

   assign outReady      = sat_v_q;
   assign out           = sat_q;
   assign earlyOutReady = ~reset & v_q[LEVELS];
`else
   assign outReady      = v_q[LEVELS];
   assign out           = root;
   assign earlyOutReady = ~reset & vld[LEVELS-1];
`endif

endmodule

// File: tb/tb_registered_adder_tree_pipe.sv
// Bench for registered_adder_tree_pipe: queue-based latency model checked every cycle,
// plus directed vectors with literal expected sums.
module tb_registered_adder_tree_pipe;

   localparam int N      = 5;
   localparam int W      = 10;
   localparam int LEVELS = 3;
   localparam int OUT_W  = W + LEVELS;
   localparam int SATW   = 12;
`ifdef ADDER_TREE_SAT_EN
   localparam int  LAT    = LEVELS + 1;
   localparam longint EXP_HI = 2047;
   localparam longint EXP_LO = -2048;
`else
   localparam int  LAT    = LEVELS;
   localparam longint EXP_HI = 2555;
   localparam longint EXP_LO = -2560;
`endif

   logic                    clk = 1'b0;
   logic                    reset, enable, inReady;
   logic [N*W-1:0]          I;
   logic                    outReady, earlyOutReady;
   logic signed [OUT_W-1:0] out;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   registered_adder_tree_pipe #(
      .IN_WIDTH   (W),
      .NUM_INPUTS (N),
      .SAT_WIDTH  (SATW)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .inReady       (inReady),
      .I             (I),
      .outReady      (outReady),
      .out           (out),
      .earlyOutReady (earlyOutReady)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic signed [63:0] got,
                      input logic signed [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   // Model: each enabled edge pushes the presented vector; it emerges LAT enabled edges later.
   typedef struct {
      bit     v;
      longint s;
   } ent_t;

   ent_t   q[$];
   ent_t   it;
   bit     m_rdy;
   longint m_out;

   function automatic longint cur_sum();
      longint s;
      s = 0;
      for (int k = 0; k < N; k++) s += longint'($signed(I[k*W +: W]));
      return s;
   endfunction

   function automatic longint clampv(longint s);
`ifdef ADDER_TREE_SAT_EN
      longint mx;
      mx = (longint'(1) <<< (SATW - 1)) - 1;
      if (s > mx) return mx;
      if (s < -mx - 1) return -mx - 1;
`endif
      return s;
   endfunction

   function automatic bit exp_early();
      if (reset) return 1'b0;
      if (LAT == 1) return inReady;
      if (q.size() == LAT - 1) return q[0].v;
      return 1'b0;
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         q.delete();
         m_rdy <= 1'b0;
         m_out <= 0;
      end else if (enable) begin
         q.push_back('{v: inReady, s: cur_sum()});
         if (q.size() >= LAT) begin
            it = q.pop_front();
            m_rdy <= it.v;
            if (it.v) m_out <= clampv(it.s);
         end else begin
            m_rdy <= 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cmp_outReady", outReady, m_rdy);
         chk("cmp_out", out, m_out);
         chk("cmp_earlyOutReady", earlyOutReady, exp_early());
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_all(input int v);
      for (int k = 0; k < N; k++) I[k*W +: W] = W'(v);
   endtask

   // Operand k = b + k, sum = 5b + 10.
   task automatic set_seq(input int b);
      for (int k = 0; k < N; k++) I[k*W +: W] = W'(b + k);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int     got_e[$];
      longint got_v[$];
      bit     pat[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      int     bas[5]  = '{1, 0, 2, 3, 0};
      longint eout[5] = '{15, 15, 20, 25, 25};

      reset = 1'b1; enable = 1'b0; inReady = 1'b0; I = '0;
      tick();
      chk_en = 1'b1;
      chk("rst_outReady", outReady, 0);
      chk("rst_out", out, 0);
      chk("rst_early", earlyOutReady, 0);
      reset = 1'b0; enable = 1'b1;

      // Single vector 1..5.
      set_seq(1); inReady = 1'b1;
      for (int e = 1; e <= LAT + 1; e++) begin
         tick();
         inReady = 1'b0;
         chk("t1_outReady", outReady, (e == LAT));
         chk("t1_early", earlyOutReady, (e == LAT - 1));
         if (e >= LAT) chk("t1_out", out, 15);
      end

      // Extremes back-to-back.
      set_all(511); inReady = 1'b1;
      tick();
      set_all(-512);
      tick();
      inReady = 1'b0;
      repeat (LAT - 2) tick();
      chk("t2_rdy0", outReady, 1);
      chk("t2_out0", out, EXP_HI);
      tick();
      chk("t2_rdy1", outReady, 1);
      chk("t2_out1", out, EXP_LO);
      tick();
      chk("t2_rdy2", outReady, 0);
      chk("t2_hold", out, EXP_LO);

      // Four vectors with a two-cycle stall after the second.
      for (int e = 1; e <= 12; e++) begin
         case (e)
            1: begin set_seq(10); inReady = 1'b1; end
            2: set_seq(20);
            3: begin set_seq(30); enable = 1'b0; end
            5: enable = 1'b1;
            6: set_seq(40);
            7: inReady = 1'b0;
            default: ;
         endcase
         tick();
         if (outReady) begin
            got_e.push_back(e);
            got_v.push_back(out);
         end
      end
      chk("t3_count", got_e.size(), 4);
      for (int i = 0; i < got_e.size() && i < 4; i++) begin
         chk("t3_edge", got_e[i], LAT + 2 + i);
         chk("t3_sum", got_v[i], 60 + 50 * i);
      end

      // Reset with two sums in flight.
      set_all(7); inReady = 1'b1;
      tick();
      set_all(8);
      tick();
      inReady = 1'b0;
      reset = 1'b1;
      #1;
      chk("t4_early_in_reset", earlyOutReady, 0);
      tick();
      chk("t4_rdy", outReady, 0);
      chk("t4_out", out, 0);
      reset = 1'b0;
      for (int i = 0; i < LAT + 2; i++) begin
         tick();
         chk("t4_stale", outReady, 0);
      end
      set_seq(-3); inReady = 1'b1;
      tick();
      inReady = 1'b0;
      repeat (LAT - 1) tick();
      chk("t4_new_rdy", outReady, 1);
      chk("t4_new_out", out, -5);

      // Bubble pattern 1,0,1,1,0.
      for (int e = 1; e <= LAT + 4; e++) begin
         if (e <= 5) begin
            inReady = pat[e-1];
            if (pat[e-1]) set_seq(bas[e-1]);
            else set_all(100);
         end else begin
            inReady = 1'b0;
         end
         tick();
         if (e >= LAT && e - LAT < 5) begin
            chk("t5_rdy", outReady, pat[e-LAT]);
            chk("t5_out", out, eout[e-LAT]);
         end
      end

      // Mixed stream with stalls and bubbles, checked by the model alone.
      for (int i = 0; i < 24; i++) begin
         enable  = (i % 5 != 4);
         inReady = (i % 3 != 1);
         for (int k = 0; k < N; k++) I[k*W +: W] = W'((i * 37 + k * 101) % 1024 - 512);
         tick();
      end
      enable = 1'b1; inReady = 1'b0;
      repeat (LAT + 2) tick();

      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
